// File: rtl/isqrt_pkg.sv
// Shared widths and state encoding for the iterative integer square root unit.
package isqrt_pkg;

  localparam int unsigned ISQRT_X_W   = 32;
  localparam int unsigned ISQRT_Y_W   = 16;
  localparam int unsigned ISQRT_REM_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqrt_state_t;

endpackage : isqrt_pkg

// File: rtl/isqrt_iter_step.sv
// One restoring digit-by-digit square root iteration (purely combinational).
// Ports:
//   rem       partial remainder going in
//   root      partial root going in
//   rad_bits  next two radicand bits, MSB first
//   rem_next  partial remainder after this iteration
//   root_next partial root with one more bit resolved
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ISQRT_REM_W-1:0] rem,
  input  logic [ISQRT_Y_W-1:0]   root,
  input  logic [1:0]             rad_bits,
  output logic [ISQRT_REM_W-1:0] rem_next,
  output logic [ISQRT_Y_W-1:0]   root_next
);

  localparam int unsigned SHIFT_W = ISQRT_REM_W + 2;

  logic [SHIFT_W-1:0] rem_shift;
  logic [SHIFT_W-1:0] trial;
  logic               ge;

  // Compare at full width so the bits above 18 still take part in the decision.
  assign rem_shift = {rem, rad_bits};
  assign trial     = {2'b00, root, 2'b01};
  assign ge        = (rem_shift >= trial);

  // The remainder is bounded by 2*root, so the 18-bit result never loses bits.
  assign rem_next  = ge ? ISQRT_REM_W'(rem_shift - trial) : ISQRT_REM_W'(rem_shift);
  assign root_next = {root[ISQRT_Y_W-2:0], ge};

endmodule : isqrt_step

// File: rtl/isqrt_iter.sv
// Iterative integer square root: y = floor(sqrt(x)), BITS_PER_CYCLE root bits
// resolved per CALC cycle. One request in flight; a new request may be
// accepted in the same cycle the previous result is presented.
// Ports:
//   clk    clock, all state updates on posedge
//   rst    asynchronous active-low reset
//   x_vld  request strobe (accepted in IDLE or DONE, ignored in CALC)
//   x      32-bit radicand
//   y_vld  one-cycle result strobe (state DONE)
//   y      16-bit root, held until the next result
//   busy   high while computing (state CALC)
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y,
  output logic                 busy
);

  localparam int unsigned CYCLES = ISQRT_Y_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4) ||
        (BITS_PER_CYCLE == 8) || (BITS_PER_CYCLE == 16))) begin : g_bad_bits_per_cycle
    $error("isqrt_iter: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  isqrt_state_t state, state_next;

  logic [ISQRT_X_W-1:0]   rad;
  logic [ISQRT_REM_W-1:0] rem;
  logic [ISQRT_Y_W-1:0]   root;
  logic [CNT_W-1:0]       cnt;
  logic [ISQRT_Y_W-1:0]   y_q;
  logic                   accept;

  logic [ISQRT_REM_W-1:0] rem_chain  [BITS_PER_CYCLE+1];
  logic [ISQRT_Y_W-1:0]   root_chain [BITS_PER_CYCLE+1];

  // Chain of iterations consuming the radicand two bits at a time from the top.
  assign rem_chain[0]  = rem;
  assign root_chain[0] = root;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    isqrt_step u_step (
      .rem       (rem_chain[i]),
      .root      (root_chain[i]),
      .rad_bits  (rad[ISQRT_X_W-1-2*i -: 2]),
      .rem_next  (rem_chain[i+1]),
      .root_next (root_chain[i+1])
    );
  end

  assign accept = x_vld && (state != CALC);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (x_vld) state_next = CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = x_vld ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, capture the root on the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      y_q  <= '0;
    end else if (accept) begin
      rad  <= x;
      rem  <= '0;
      root <= '0;
      cnt  <= CNT_LOAD;
    end else if (state == CALC) begin
      rad  <= rad << (2 * BITS_PER_CYCLE);
      rem  <= rem_chain[BITS_PER_CYCLE];
      root <= root_chain[BITS_PER_CYCLE];
      cnt  <= cnt - CNT_W'(1);
      if (cnt == '0) begin
        y_q <= root_chain[BITS_PER_CYCLE];
      end
    end
  end

  assign y     = y_q;
  assign y_vld = (state == DONE);
  assign busy  = (state == CALC);

endmodule : isqrt_iter

// File: tb/tb_isqrt_iter.sv
// Self-checking bench for isqrt_iter: directed corner cases on a K=1 instance
// plus a randomized sweep across all legal BITS_PER_CYCLE values in parallel.
module tb_isqrt_iter;

  localparam int NINST = 5;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic [NINST-1:0] yv;
  logic [NINST-1:0] bz;
  logic [15:0] yy [NINST];

  int total;
  int bad;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    isqrt_iter #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (yv[g]),
      .y     (yy[g]),
      .busy  (bz[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: largest r with r*r <= v, from real sqrt then corrected in 64 bits.
  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    longint unsigned r;
    longint unsigned vv;
    vv = longint'(v);
    r  = longint'($floor($sqrt(real'(v))));
    while (r * r > vv) r = r - 1;
    while ((r + 1) * (r + 1) <= vv) r = r + 1;
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait for instance 0's result; lat=-1 on timeout.
  task automatic issue_wait(input logic [31:0] xv, output int lat);
    x     = xv;
    x_vld = 1'b1;
    tick();
    x_vld = 1'b0;
    lat   = 1;
    while (!yv[0] && lat < 40) begin
      tick();
      lat++;
    end
    if (!yv[0]) lat = -1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    x_vld = 1'b0;
    x     = '0;
    tick();
    tick();
    for (int g = 0; g < NINST; g++) begin
      total++;
      if (yv[g] !== 1'b0 || bz[g] !== 1'b0 || yy[g] !== 16'h0) begin
        bad++;
        $display("FAIL reset inst%0d: y_vld=%b busy=%b y=%h, required 0/0/0000", g, yv[g], bz[g], yy[g]);
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_small();
    logic [31:0] xs [5];
    logic [15:0] ys [5];
    int lat;
    xs = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    ys = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    for (int i = 0; i < 5; i++) begin
      issue_wait(xs[i], lat);
      total++;
      if (lat !== 17) begin
        bad++;
        $display("FAIL small_lat x=%0d: latency=%0d, required 17", xs[i], lat);
      end
      total++;
      if (yy[0] !== ys[i]) begin
        bad++;
        $display("FAIL small_y x=%0d: y=%0d, required %0d", xs[i], yy[0], ys[i]);
      end
      tick();
      total++;
      if (yv[0] !== 1'b0) begin
        bad++;
        $display("FAIL small_width x=%0d: y_vld still %b one cycle later, required 0", xs[i], yv[0]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] xs [4];
    logic [15:0] ys [4];
    int lat;
    xs = '{32'hFFFF_FFFF, 32'd1000000, 32'hFFFE_0001, 32'hFFFE_0000};
    ys = '{16'hFFFF, 16'd1000, 16'hFFFF, 16'hFFFE};
    for (int i = 0; i < 4; i++) begin
      issue_wait(xs[i], lat);
      total++;
      if (yy[0] !== ys[i] || lat !== 17) begin
        bad++;
        $display("FAIL boundary x=%h: y=%h lat=%0d, required y=%h lat=17", xs[i], yy[0], lat, ys[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue_wait(32'd9, lat);
    total++;
    if (yy[0] !== 16'd3 || lat !== 17) begin
      bad++;
      $display("FAIL b2b_first: y=%0d lat=%0d, required y=3 lat=17", yy[0], lat);
    end
    // Still in the DONE cycle: issue the next request right away.
    issue_wait(32'd7, lat);
    total++;
    if (yy[0] !== 16'd2 || lat !== 17) begin
      bad++;
      $display("FAIL b2b_second: y=%0d gap=%0d, required y=2 gap=17", yy[0], lat);
    end
    tick();
  endtask

  task automatic test_ignore_in_calc();
    int busy_low;
    int extra;
    int seen_at;
    busy_low = 0;
    extra    = 0;
    seen_at  = -1;
    x     = 32'd16;
    x_vld = 1'b1;
    tick();
    x_vld = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin
        x     = 32'd100;
        x_vld = 1'b1;
      end else begin
        x_vld = 1'b0;
      end
      if (c <= 16 && !bz[0]) busy_low++;
      if (yv[0]) begin
        if (seen_at < 0) seen_at = c;
        else extra++;
      end
      if (seen_at == c) begin
        total++;
        if (yy[0] !== 16'd4) begin
          bad++;
          $display("FAIL ignore_y: y=%0d, required 4", yy[0]);
        end
      end
      tick();
    end
    x_vld = 1'b0;
    total++;
    if (seen_at !== 17) begin
      bad++;
      $display("FAIL ignore_lat: y_vld at %0d, required 17", seen_at);
    end
    total++;
    if (busy_low !== 0) begin
      bad++;
      $display("FAIL ignore_busy: busy low in %0d CALC cycles, required 0", busy_low);
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignore_extra: %0d extra results, required 0", extra);
    end
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    seen = 0;
    x     = 32'd1000000;
    x_vld = 1'b1;
    tick();
    x_vld = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    total++;
    if (yv[0] !== 1'b0 || bz[0] !== 1'b0 || yy[0] !== 16'h0) begin
      bad++;
      $display("FAIL abort_async: y_vld=%b busy=%b y=%h, required 0/0/0000", yv[0], bz[0], yy[0]);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (yv[0]) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_novld: %0d results after abort, required 0", seen);
    end
    issue_wait(32'd49, lat);
    total++;
    if (yy[0] !== 16'd7 || lat !== 17) begin
      bad++;
      $display("FAIL abort_after: y=%0d lat=%0d, required y=7 lat=17", yy[0], lat);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [31:0] xv;
    logic [15:0] exp_y;
    logic [31:0] r;
    int lat   [NINST];
    int pulses[NINST];
    logic [15:0] got[NINST];
    for (int n = 0; n < 200; n++) begin
      case (n % 4)
        0: xv = $urandom;
        1: xv = $urandom_range(0, 1000);
        2: begin
          r  = $urandom_range(1, 65535);
          xv = r * r - $urandom_range(0, 1);
        end
        default: xv = 32'hFFFF_FFFF - $urandom_range(0, 255);
      endcase
      exp_y = isqrt_ref(xv);
      for (int g = 0; g < NINST; g++) begin
        lat[g]    = -1;
        pulses[g] = 0;
        got[g]    = '0;
      end
      x     = xv;
      x_vld = 1'b1;
      tick();
      x_vld = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        for (int g = 0; g < NINST; g++) begin
          if (yv[g]) begin
            pulses[g]++;
            if (lat[g] < 0) begin
              lat[g] = c;
              got[g] = yy[g];
            end
          end
        end
        tick();
      end
      for (int g = 0; g < NINST; g++) begin
        total++;
        if (got[g] !== exp_y) begin
          bad++;
          $display("FAIL sweep_y K=%0d x=%h: y=%h, required %h", 1 << g, xv, got[g], exp_y);
        end
        total++;
        if (lat[g] !== (16 >> g) + 1) begin
          bad++;
          $display("FAIL sweep_lat K=%0d x=%h: latency=%0d, required %0d", 1 << g, xv, lat[g], (16 >> g) + 1);
        end
        total++;
        if (pulses[g] !== 1) begin
          bad++;
          $display("FAIL sweep_pulses K=%0d x=%h: %0d strobes, required 1", 1 << g, xv, pulses[g]);
        end
      end
    end
  endtask

  // Client formula chain: s1 = isqrt(c), s2 = isqrt(s1 + b), res = isqrt(s2 + a).
  task automatic test_chain();
    logic [31:0] a, b, c;
    logic [31:0] in1, in2;
    logic [31:0] exp_in1, exp_in2;
    logic [15:0] exp_res;
    int lat;
    a = 32'd1;
    b = 32'd4;
    c = 32'd9;
    exp_in1 = 32'(isqrt_ref(c)) + b;
    exp_in2 = 32'(isqrt_ref(exp_in1)) + a;
    exp_res = isqrt_ref(exp_in2);
    issue_wait(c, lat);
    in1 = 32'(yy[0]) + b;
    total++;
    if (in1 !== exp_in1) begin
      bad++;
      $display("FAIL chain_in1: %0d, required %0d", in1, exp_in1);
    end
    issue_wait(in1, lat);
    in2 = 32'(yy[0]) + a;
    total++;
    if (in2 !== exp_in2) begin
      bad++;
      $display("FAIL chain_in2: %0d, required %0d", in2, exp_in2);
    end
    issue_wait(in2, lat);
    total++;
    if (yy[0] !== exp_res || yy[0] !== 16'd1 || lat !== 17) begin
      bad++;
      $display("FAIL chain_res: res=%0d lat=%0d, required res=1 lat=17", yy[0], lat);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_small();
    test_boundary();
    test_back_to_back();
    test_ignore_in_calc();
    test_abort();
    test_sweep();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_isqrt_iter
